core_seq: RTL

- Parametrised successor of the core's single-IRQ control sequencer.
- Sequences instruction fetch, execute, multi-beat data access and interrupt entry/exit over the instruction and data request/grant/valid buses.
- Adds vs. previous generation: NUM_IRQ prioritised interrupt lines with enable, configurable beat count up to MAX_BEATS, and a per-handshake bus timeout with error reporting.
- Sits between the bus ports and the datapath; drives PC/instruction-register enables.

---
 rtl/core_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// Core control sequencer: fetch, execute, multi-beat data access and
// prioritised interrupt entry/exit, with a per-handshake bus timeout.
module core_seq #(
    parameter int NUM_IRQ   = 4,
    parameter int MAX_BEATS = 4,
    parameter int TIMEOUT   = 255,
    parameter int IDW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk_i,
    input  logic               res_n_i,
    input  logic               instr_gnt_i,
    input  logic               instr_r_valid_i,
    output logic               instr_req_o,
    input  logic               data_gnt_i,
    input  logic               data_r_valid_i,
    output logic               data_req_o,
    output logic               data_we_o,
    input  logic               mem_access_i,
    input  logic               mem_write_i,
    input  logic [BW-1:0]      beats_i,
    output logic [BW-1:0]      beat_idx_o,
    input  logic               mret_exec_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               irq_en_i,
    output logic               irq_ack_o,
    output logic [IDW-1:0]     irq_id_o,
    output logic               in_handler_o,
    output logic               pc_en_o,
    output logic               pc_backup_en_o,
    output logic               instr_en_o,
    output logic               instr_done_o,
    output logic               bus_err_o
);

    // state   | meaning
    // INIT    | first cycle after reset
    // IF_REQ  | instruction request, waiting for grant
    // IF_WAIT | waiting for instruction read data
    // EXE     | execute / decode sampling, PC update
    // D_REQ   | data request, waiting for grant
    // D_WAIT  | load beat granted, waiting for read data
    // TRAP    | interrupt entry, one cycle
    // ERR     | bus timeout report, one cycle, refetch follows
    typedef enum logic [2:0] {
        INIT, IF_REQ, IF_WAIT, EXE, D_REQ, D_WAIT, TRAP, ERR
    } state_t;

    localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT);

    state_t               state_q, state_d;
    logic [BW-1:0]        beat_idx_q, beat_idx_d;
    logic [BW-1:0]        beats_q, beats_d;
    logic                 we_q, we_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic                 in_handler_q, in_handler_d;
    logic [IDW-1:0]       irq_id_q, irq_id_d;

    logic                 instr_req_q, instr_en_q, pc_en_q, pc_backup_en_q;
    logic                 irq_ack_q, data_req_q, data_we_q, bus_err_q;

    logic                 waiting, hs, beat_done, trap_go;
    logic [BW-1:0]        beats_eff;

    always_comb begin
        beats_eff = beats_i;
        if (beats_i == '0) begin
            beats_eff = BW'(1);
        end else if (beats_i > BW'(MAX_BEATS)) begin
            beats_eff = BW'(MAX_BEATS);
        end
    end

    // An MRET retiring in EXE already counts as having left the handler.
    assign trap_go = irq_en_i && !in_handler_d && (|pending_q);

    always_comb begin
        in_handler_d = in_handler_q;
        if (state_q == EXE && mret_exec_i) begin
            in_handler_d = 1'b0;
        end else if (state_q == TRAP) begin
            in_handler_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        beats_d      = beats_q;
        we_d         = we_q;
        tmo_d        = '0;
        pending_d    = pending_q | irq_i;
        irq_id_d     = irq_id_q;
        instr_done_o = 1'b0;
        waiting      = 1'b0;
        hs           = 1'b0;
        beat_done    = 1'b0;

        case (state_q)
            INIT: state_d = IF_REQ;
            IF_REQ: begin
                waiting = 1'b1;
                hs      = instr_gnt_i;
                if (hs) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                waiting = 1'b1;
                hs      = instr_r_valid_i;
                if (hs) state_d = EXE;
            end
            EXE: begin
                we_d       = mem_write_i;
                beats_d    = beats_eff;
                beat_idx_d = '0;
                if (mem_access_i) begin
                    state_d = D_REQ;
                end else begin
                    instr_done_o = 1'b1;
                    state_d      = trap_go ? TRAP : IF_REQ;
                end
            end
            D_REQ: begin
                waiting = 1'b1;
                hs      = data_gnt_i;
                if (hs) begin
                    if (we_q) beat_done = 1'b1;
                    else      state_d   = D_WAIT;
                end
            end
            D_WAIT: begin
                waiting   = 1'b1;
                hs        = data_r_valid_i;
                beat_done = hs;
            end
            TRAP: begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (irq_id_q == IDW'(i)) pending_d[i] = 1'b0;
                end
                state_d = IF_REQ;
            end
            ERR:     state_d = IF_REQ;
            default: state_d = INIT;
        endcase

        if (beat_done) begin
            if ((beat_idx_q + BW'(1)) < beats_q) begin
                beat_idx_d = beat_idx_q + BW'(1);
                state_d    = D_REQ;
            end else begin
                instr_done_o = 1'b1;
                state_d      = trap_go ? TRAP : IF_REQ;
            end
        end

        // A handshake in the terminal-count cycle takes priority over the timeout.
        if (waiting && !hs && (TIMEOUT != 0)) begin
            if (tmo_q == TO_CNT) begin
                state_d = ERR;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (state_d == TRAP) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (pending_d[i]) irq_id_d = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q        <= INIT;
            beat_idx_q     <= '0;
            beats_q        <= '0;
            we_q           <= 1'b0;
            tmo_q          <= '0;
            pending_q      <= '0;
            in_handler_q   <= 1'b0;
            irq_id_q       <= '0;
            instr_req_q    <= 1'b0;
            instr_en_q     <= 1'b0;
            pc_en_q        <= 1'b0;
            pc_backup_en_q <= 1'b0;
            irq_ack_q      <= 1'b0;
            data_req_q     <= 1'b0;
            data_we_q      <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_idx_q     <= beat_idx_d;
            beats_q        <= beats_d;
            we_q           <= we_d;
            tmo_q          <= tmo_d;
            pending_q      <= pending_d;
            in_handler_q   <= in_handler_d;
            irq_id_q       <= irq_id_d;
            instr_req_q    <= (state_d == IF_REQ);
            instr_en_q     <= (state_d == IF_WAIT);
            pc_en_q        <= (state_d == EXE) || (state_d == TRAP);
            pc_backup_en_q <= (state_d == TRAP);
            irq_ack_q      <= (state_d == TRAP);
            data_req_q     <= (state_d == D_REQ);
            data_we_q      <= (state_d == D_REQ) && we_d;
            bus_err_q      <= (state_d == ERR);
        end
    end

    assign instr_req_o    = instr_req_q;
    assign instr_en_o     = instr_en_q;
    assign pc_en_o        = pc_en_q;
    assign pc_backup_en_o = pc_backup_en_q;
    assign irq_ack_o      = irq_ack_q;
    assign irq_id_o       = irq_id_q;
    assign in_handler_o   = in_handler_q;
    assign data_req_o     = data_req_q;
    assign data_we_o      = data_we_q;
    assign bus_err_o      = bus_err_q;
    assign beat_idx_o     = beat_idx_q;

endmodule
